cordic_seq_ctrl: RTL and testbench



---
 rtl/cordic_seq_ctrl.sv | 143 ++++++++++++++
 tb/tb_cordic_seq_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_seq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : cordic_seq_ctrl                                            |
// | Description : Control FSM sequencing one CORDIC run: drives the          |
// |               iteration counter (opcode + terminal value), datapath      |
// |               load/iterate strobes and start / valid-ready handshakes.   |
// |               Optional watchdog: define CORDIC_SEQ_TIMEOUT_EN.           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module cordic_seq_ctrl #(
  parameter int N = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic [N-1:0] n_i,
  input  logic         z_i,
  output logic [1:0]   opc_o,
  output logic [N-1:0] n_o,
  output logic         ld_o,
  output logic         en_o,
  output logic         busy_o,
  output logic         valid_o,
  input  logic         ready_i,
  output logic         err_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_ITER = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [1:0] c_OPC_CLEAR = 2'd0;
  localparam logic [1:0] c_OPC_HOLD  = 2'd1;
  localparam logic [1:0] c_OPC_INC   = 2'd2;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [N-1:0] r_n;
  logic         w_accept;
  logic         w_timeout;

  assign w_accept = (r_state == S_IDLE) && start_i;

`ifdef CORDIC_SEQ_TIMEOUT_EN
  // Watchdog is held at zero outside ITER, so it starts from zero on entry.
  logic [N:0] r_wdog;
  logic [N:0] w_wdog_lim;
  logic       r_err;

  assign w_wdog_lim = {1'b0, r_n} + {{N{1'b0}}, 1'b1};
  assign w_timeout  = (r_state == S_ITER) && !z_i && (r_wdog == w_wdog_lim);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wdog <= '0;
    end else if (r_state != S_ITER) begin
      r_wdog <= '0;
    end else begin
      r_wdog <= r_wdog + {{N{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_err <= 1'b0;
    end else if (w_accept) begin
      r_err <= 1'b0;
    end else if (w_timeout) begin
      r_err <= 1'b1;
    end
  end

  assign err_o = r_err;
`else
  assign w_timeout = 1'b0;
  assign err_o     = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Terminal value is captured only on an accepted start and held for the run.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_n <= '0;
    end else if (w_accept) begin
      r_n <= n_i;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    opc_o       = c_OPC_CLEAR;
    en_o        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        opc_o       = c_OPC_HOLD;
        w_state_nxt = S_ITER;
      end
      S_ITER: begin
        if (w_timeout) begin
          opc_o       = c_OPC_CLEAR;
          w_state_nxt = S_DONE;
        end else if (z_i) begin
          opc_o       = c_OPC_HOLD;
          w_state_nxt = S_DONE;
        end else begin
          opc_o = c_OPC_INC;
          en_o  = 1'b1;
        end
      end
      S_DONE: begin
        opc_o = c_OPC_HOLD;
        if (ready_i) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign n_o     = r_n;
  assign ld_o    = (r_state == S_LOAD);
  assign busy_o  = (r_state != S_IDLE);
  assign valid_o = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_cordic_seq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_cordic_seq_ctrl                                         |
// | Description : Self-checking bench for cordic_seq_ctrl with a model       |
// |               iteration counter and a per-run scoreboard.                |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_cordic_seq_ctrl;

  typedef struct {
    logic [3:0] n;
    int         rwait;
    int         exp_en;
    int         exp_vrel;
    logic       exp_err;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] n_in;
  logic       z;
  logic [1:0] opc_o;
  logic [3:0] n_o;
  logic       ld_o, en_o, busy_o, valid_o, err_o;
  logic       ready;

  logic [3:0] cnt;
  logic       z_force;

  int n_tests = 0;
  int n_fail  = 0;

  vec_t sb[$];
  vec_t vecs[5];

  int rel    = 0;
  int en_cnt = 0;
  int vrel   = 0;

  int exp_opc[9]   = '{0, 1, 2, 2, 2, 2, 1, 1, 0};
  int exp_en[9]    = '{0, 0, 1, 1, 1, 1, 0, 0, 0};
  int exp_ld[9]    = '{0, 1, 0, 0, 0, 0, 0, 0, 0};
  int exp_busy[9]  = '{0, 1, 1, 1, 1, 1, 1, 1, 0};
  int exp_valid[9] = '{0, 0, 0, 0, 0, 0, 0, 1, 0};

  always #5 clk = ~clk;

  cordic_seq_ctrl #(.N(4)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start),
    .n_i     (n_in),
    .z_i     (z),
    .opc_o   (opc_o),
    .n_o     (n_o),
    .ld_o    (ld_o),
    .en_o    (en_o),
    .busy_o  (busy_o),
    .valid_o (valid_o),
    .ready_i (ready),
    .err_o   (err_o)
  );

  // Model iteration counter: 0 clear, 1 hold, 2 increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 4'd0;
    end else begin
      case (opc_o)
        2'd0:    cnt <= 4'd0;
        2'd2:    cnt <= cnt + 4'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign z = z_force ? 1'b0 : (cnt == n_o);

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Per-run monitor: counts en_o pulses relative to LOAD and scores each handshake.
  always @(negedge clk) begin
    vec_t e;
    if (!rst) begin
      if (ld_o) begin
        rel    = 1;
        en_cnt = 0;
        vrel   = 0;
      end else begin
        rel++;
      end
      if (en_o) en_cnt++;
      if (valid_o && vrel == 0) vrel = rel;
      if (valid_o && ready) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_result", 1, 0);
        end else begin
          e = sb.pop_front();
          check("sb_n_o", int'(n_o), int'(e.n));
          check("sb_en_pulses", en_cnt, e.exp_en);
          check("sb_valid_cycle", vrel, e.exp_vrel);
          check("sb_err", int'(err_o), int'(e.exp_err));
        end
      end
    end
  end

  task automatic run_vec(input vec_t v);
    bit got;
    @(posedge clk); #1;
    start = 1'b1;
    n_in  = v.n;
    ready = (v.rwait == 0);
    sb.push_back(v);
    @(posedge clk); #1;
    start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (valid_o) begin
        got = 1'b1;
        break;
      end
    end
    check("valid_seen", int'(got), 1);
    if (got) begin
      if (v.rwait > 0) begin
        repeat (v.rwait) @(posedge clk);
        #1;
        ready = 1'b1;
      end
      @(posedge clk); #1;
      ready = 1'b0;
      @(negedge clk);
      check("idle_after_handshake", int'(busy_o), 0);
    end
  endtask

  initial begin
    bit got;
    vecs[0] = '{4'd4,  0, 4,  7,  1'b0};
    vecs[1] = '{4'd0,  0, 0,  3,  1'b0};
    vecs[2] = '{4'd15, 0, 15, 18, 1'b0};
    vecs[3] = '{4'd1,  3, 1,  4,  1'b0};
    vecs[4] = '{4'd7,  1, 7,  10, 1'b0};

    rst = 1'b1; start = 1'b0; n_in = 4'd0; ready = 1'b0; z_force = 1'b0;
    #3;
    check("rst_outputs", int'({opc_o, n_o, ld_o, en_o, busy_o, valid_o, err_o}), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("idle_after_reset", int'({opc_o, busy_o}), 0);

    // Cycle-exact run, n=4, ready held high.
    @(posedge clk); #1;
    start = 1'b1; n_in = 4'd4; ready = 1'b1;
    sb.push_back('{4'd4, 0, 4, 7, 1'b0});
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      check($sformatf("seqA_c%0d_opc", c), int'(opc_o), exp_opc[c]);
      check($sformatf("seqA_c%0d_strobes", c), int'({en_o, ld_o, busy_o, valid_o}),
            (exp_en[c] << 3) | (exp_ld[c] << 2) | (exp_busy[c] << 1) | exp_valid[c]);
      if (c == 0) begin
        @(posedge clk); #1;
        start = 1'b0;
      end
    end
    ready = 1'b0;

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Held result with start ignored in DONE, then back-to-back restart.
    @(posedge clk); #1;
    start = 1'b1; n_in = 4'd3; ready = 1'b0;
    sb.push_back('{4'd3, 0, 3, 6, 1'b0});
    @(posedge clk); #1;
    start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (valid_o) begin
        got = 1'b1;
        break;
      end
    end
    check("seqC_valid_seen", int'(got), 1);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      start = (k == 3);
      n_in  = 4'd9;
      @(negedge clk);
      check($sformatf("seqC_hold%0d", k), int'({valid_o, opc_o, n_o}), {1'b1, 2'd1, 4'd3});
    end
    @(posedge clk); #1;
    start = 1'b0; ready = 1'b1;
    @(negedge clk);
    check("seqC_valid_before_accept", int'(valid_o), 1);
    @(posedge clk); #1;
    ready = 1'b0; start = 1'b1; n_in = 4'd2;
    sb.push_back('{4'd2, 0, 2, 5, 1'b0});
    @(negedge clk);
    check("seqC_idle_after_accept", int'({busy_o, valid_o}), 0);
    @(posedge clk); #1;
    start = 1'b0; ready = 1'b1;
    @(negedge clk);
    check("b2b_load", int'({ld_o, n_o}), {1'b1, 4'd2});
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (valid_o) begin
        got = 1'b1;
        break;
      end
    end
    check("b2b_valid_seen", int'(got), 1);
    @(posedge clk); #1;
    ready = 1'b0;

    // Asynchronous reset in the middle of ITER.
    @(posedge clk); #1;
    start = 1'b1; n_in = 4'd5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("rstmid_en_before", int'(en_o), 1);
    rst = 1'b1;
    sb.delete();
    #1;
    check("rstmid_outputs", int'({opc_o, n_o, ld_o, en_o, busy_o, valid_o, err_o}), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("rstmid_idle", int'({opc_o, busy_o, ld_o}), 0);
    end
    run_vec('{4'd1, 0, 1, 4, 1'b0});

`ifdef CORDIC_SEQ_TIMEOUT_EN
    z_force = 1'b1;
    run_vec('{4'd3, 0, 4, 7, 1'b1});
    z_force = 1'b0;
    check("err_sticky_idle", int'(err_o), 1);
    run_vec('{4'd2, 0, 2, 5, 1'b0});
`endif

    repeat (3) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
